small_fifo: RTL and testbench

Parameterised small synchronous FIFO (depth 1 or 2) with registered data and status outputs and a valid/ready-style ENQ/DEQ interface.
- Replaces the separate one-entry and two-entry queue primitives.
- Used as the operand and result queues in the interface datapath, e.g. write-side capture of operands and read-side result buffering.

---
 rtl/small_fifo_pkg.sv | 14 +
 rtl/small_fifo.sv | 131 +++++++++++++
 tb/tb_small_fifo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/small_fifo_pkg.sv
// Shared constants and occupancy encoding for small_fifo.
package small_fifo_pkg;

  localparam int unsigned DEPTH_ONE = 1;
  localparam int unsigned DEPTH_TWO = 2;
  localparam int unsigned CNT_W     = 2;

  typedef enum logic [CNT_W-1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_TWO   = 2'd2
  } count_e;

endpackage

// File: rtl/small_fifo.sv
// Depth-1/2 synchronous FIFO with registered data and status outputs.
// Optional simulation checks are enabled by SMALL_FIFO_ERROR_CHECK_EN.
module small_fifo
  import small_fifo_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] D_IN,
  input  logic             ENQ,
  input  logic             DEQ,
  input  logic             CLR,
  output logic [width-1:0] D_OUT,
  output logic             FULL_N,
  output logic             EMPTY_N
);

  logic [width-1:0] head_q;
  logic             full_n_q;
  logic             empty_n_q;
  count_e           count_q;
  logic             enq;
  logic             deq;

  assign enq     = ENQ & full_n_q;
  assign deq     = DEQ & empty_n_q;
  assign D_OUT   = head_q;
  assign FULL_N  = full_n_q;
  assign EMPTY_N = empty_n_q;

  if (depth == DEPTH_ONE) begin : g_depth1
    // FULL_N and EMPTY_N are complementary here, so enq and deq never coincide.
    always_ff @(posedge CLK) begin
      if (RST) begin
        count_q   <= CNT_EMPTY;
        head_q    <= '0;
        empty_n_q <= 1'b0;
        full_n_q  <= 1'b1;
      end else if (CLR) begin
        count_q   <= CNT_EMPTY;
        empty_n_q <= 1'b0;
        full_n_q  <= 1'b1;
      end else begin
        case (count_q)
          CNT_EMPTY: if (enq) begin
            head_q    <= D_IN;
            count_q   <= CNT_ONE;
            empty_n_q <= 1'b1;
            full_n_q  <= 1'b0;
          end
          CNT_ONE: if (deq) begin
            count_q   <= CNT_EMPTY;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
          end
          default: begin
            count_q   <= CNT_EMPTY;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
          end
        endcase
      end
    end
  end else begin : g_depth2
    logic [width-1:0] tail_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        count_q   <= CNT_EMPTY;
        head_q    <= '0;
        tail_q    <= '0;
        empty_n_q <= 1'b0;
        full_n_q  <= 1'b1;
      end else if (CLR) begin
        count_q   <= CNT_EMPTY;
        empty_n_q <= 1'b0;
        full_n_q  <= 1'b1;
      end else begin
        case (count_q)
          CNT_EMPTY: if (enq) begin
            head_q    <= D_IN;
            count_q   <= CNT_ONE;
            empty_n_q <= 1'b1;
          end
          CNT_ONE: begin
            if (enq && deq) begin
              head_q <= D_IN;
            end else if (enq) begin
              tail_q   <= D_IN;
              count_q  <= CNT_TWO;
              full_n_q <= 1'b0;
            end else if (deq) begin
              count_q   <= CNT_EMPTY;
              empty_n_q <= 1'b0;
            end
          end
          CNT_TWO: if (deq) begin
            head_q   <= tail_q;
            count_q  <= CNT_ONE;
            full_n_q <= 1'b1;
          end
          default: begin
            count_q   <= CNT_EMPTY;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef SMALL_FIFO_ERROR_CHECK_EN
`ifndef SYNTHESIS
  if (depth != DEPTH_ONE && depth != DEPTH_TWO) begin : g_depth_chk
    $fatal(1, "small_fifo: illegal depth %0d (must be 1 or 2)", depth);
  end

  always @(posedge CLK) begin
    if (!RST) begin
      if (ENQ && !full_n_q)
        $error("%m: enqueue to full FIFO at time %0t", $time);
      if (DEQ && !empty_n_q)
        $error("%m: dequeue from empty FIFO at time %0t", $time);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_small_fifo.sv
// Directed self-checking bench for small_fifo at depth 2 and depth 1.
module tb_small_fifo;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;

  logic [7:0] d2_din = '0;
  logic       d2_enq = 1'b0, d2_deq = 1'b0, d2_clr = 1'b0;
  logic [7:0] d2_dout;
  logic       d2_full_n, d2_empty_n;

  logic [7:0] d1_din = '0;
  logic       d1_enq = 1'b0, d1_deq = 1'b0, d1_clr = 1'b0;
  logic [7:0] d1_dout;
  logic       d1_full_n, d1_empty_n;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  always #5 CLK = ~CLK;

  small_fifo #(.width(8), .depth(2)) u_d2 (
    .CLK(CLK), .RST(RST), .D_IN(d2_din), .ENQ(d2_enq), .DEQ(d2_deq), .CLR(d2_clr),
    .D_OUT(d2_dout), .FULL_N(d2_full_n), .EMPTY_N(d2_empty_n)
  );

  small_fifo #(.width(8), .depth(1)) u_d1 (
    .CLK(CLK), .RST(RST), .D_IN(d1_din), .ENQ(d1_enq), .DEQ(d1_deq), .CLR(d1_clr),
    .D_OUT(d1_dout), .FULL_N(d1_full_n), .EMPTY_N(d1_empty_n)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    d2_enq = 1'b0; d2_deq = 1'b0; d2_clr = 1'b0;
    d1_enq = 1'b0; d1_deq = 1'b0; d1_clr = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_inputs();
    step();
    step();
    RST = 1'b0;
    total_cnt++;
    if (d2_empty_n !== 1'b0) $display("FAIL reset_d2_empty_n got %b exp 0", d2_empty_n); else pass_cnt++;
    total_cnt++;
    if (d2_full_n !== 1'b1) $display("FAIL reset_d2_full_n got %b exp 1", d2_full_n); else pass_cnt++;
    total_cnt++;
    if (d2_dout !== 8'h00) $display("FAIL reset_d2_dout got %h exp 00", d2_dout); else pass_cnt++;
    total_cnt++;
    if (d1_empty_n !== 1'b0 || d1_full_n !== 1'b1 || d1_dout !== 8'h00)
      $display("FAIL reset_d1 got empty_n=%b full_n=%b dout=%h exp 0 1 00", d1_empty_n, d1_full_n, d1_dout);
    else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    d2_din = 8'h0F; d2_enq = 1'b1;
    step();
    total_cnt++;
    if (d2_empty_n !== 1'b1 || d2_full_n !== 1'b1 || d2_dout !== 8'h0F)
      $display("FAIL fill1 got empty_n=%b full_n=%b dout=%h exp 1 1 0f", d2_empty_n, d2_full_n, d2_dout);
    else pass_cnt++;
    d2_din = 8'hF0;
    step();
    total_cnt++;
    if (d2_full_n !== 1'b0) $display("FAIL fill2_full_n got %b exp 0", d2_full_n); else pass_cnt++;
    total_cnt++;
    if (d2_dout !== 8'h0F) $display("FAIL fill2_dout got %h exp 0f", d2_dout); else pass_cnt++;
    d2_enq = 1'b0; d2_deq = 1'b1;
    step();
    total_cnt++;
    if (d2_dout !== 8'hF0 || d2_full_n !== 1'b1 || d2_empty_n !== 1'b1)
      $display("FAIL drain1 got dout=%h full_n=%b empty_n=%b exp f0 1 1", d2_dout, d2_full_n, d2_empty_n);
    else pass_cnt++;
    step();
    d2_deq = 1'b0;
    total_cnt++;
    if (d2_empty_n !== 1'b0 || d2_full_n !== 1'b1 || d2_dout !== 8'hF0)
      $display("FAIL drain2 got empty_n=%b full_n=%b dout=%h exp 0 1 f0", d2_empty_n, d2_full_n, d2_dout);
    else pass_cnt++;
  endtask

  task automatic test_simul_enq_deq();
    d2_din = 8'h11; d2_enq = 1'b1;
    step();
    d2_din = 8'h22; d2_deq = 1'b1;
    step();
    d2_enq = 1'b0; d2_deq = 1'b0;
    total_cnt++;
    if (d2_dout !== 8'h22 || d2_full_n !== 1'b1 || d2_empty_n !== 1'b1)
      $display("FAIL simul got dout=%h full_n=%b empty_n=%b exp 22 1 1", d2_dout, d2_full_n, d2_empty_n);
    else pass_cnt++;
    d2_deq = 1'b1;
    step();
    total_cnt++;
    if (d2_empty_n !== 1'b0) $display("FAIL simul_drain_empty_n got %b exp 0", d2_empty_n); else pass_cnt++;
    // DEQ while empty must be ignored.
    step();
    d2_deq = 1'b0;
    total_cnt++;
    if (d2_empty_n !== 1'b0 || d2_full_n !== 1'b1 || d2_dout !== 8'h22)
      $display("FAIL deq_empty got empty_n=%b full_n=%b dout=%h exp 0 1 22", d2_empty_n, d2_full_n, d2_dout);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    d2_enq = 1'b1; d2_din = 8'hA1;
    step();
    d2_din = 8'hA2;
    step();
    // At count 2 the ENQ is ignored even with DEQ; head advances to the tail.
    d2_din = 8'hA3; d2_deq = 1'b1;
    step();
    d2_enq = 1'b0;
    total_cnt++;
    if (d2_dout !== 8'hA2 || d2_full_n !== 1'b1 || d2_empty_n !== 1'b1)
      $display("FAIL full_enq_deq got dout=%h full_n=%b empty_n=%b exp a2 1 1", d2_dout, d2_full_n, d2_empty_n);
    else pass_cnt++;
    step();
    d2_deq = 1'b0;
    total_cnt++;
    if (d2_empty_n !== 1'b0) $display("FAIL full_enq_deq_drain got empty_n=%b exp 0", d2_empty_n); else pass_cnt++;
  endtask

  task automatic test_depth1();
    d1_din = 8'hAB; d1_enq = 1'b1;
    step();
    total_cnt++;
    if (d1_full_n !== 1'b0 || d1_empty_n !== 1'b1 || d1_dout !== 8'hAB)
      $display("FAIL d1_enq got full_n=%b empty_n=%b dout=%h exp 0 1 ab", d1_full_n, d1_empty_n, d1_dout);
    else pass_cnt++;
    d1_din = 8'hCD;
    step();
    d1_enq = 1'b0;
    total_cnt++;
    if (d1_dout !== 8'hAB || d1_full_n !== 1'b0)
      $display("FAIL d1_enq_full got dout=%h full_n=%b exp ab 0", d1_dout, d1_full_n);
    else pass_cnt++;
    d1_deq = 1'b1;
    step();
    d1_deq = 1'b0;
    total_cnt++;
    if (d1_empty_n !== 1'b0 || d1_full_n !== 1'b1 || d1_dout !== 8'hAB)
      $display("FAIL d1_deq got empty_n=%b full_n=%b dout=%h exp 0 1 ab", d1_empty_n, d1_full_n, d1_dout);
    else pass_cnt++;
    d1_enq = 1'b1;
    step();
    d1_enq = 1'b0;
    total_cnt++;
    if (d1_dout !== 8'hCD || d1_empty_n !== 1'b1)
      $display("FAIL d1_reenq got dout=%h empty_n=%b exp cd 1", d1_dout, d1_empty_n);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    d2_enq = 1'b1; d2_din = 8'h01;
    step();
    d2_din = 8'h02;
    step();
    d2_din = 8'h09; d2_deq = 1'b1; d2_clr = 1'b1;
    step();
    d2_enq = 1'b0; d2_deq = 1'b0; d2_clr = 1'b0;
    total_cnt++;
    if (d2_empty_n !== 1'b0 || d2_full_n !== 1'b1 || d2_dout !== 8'h01)
      $display("FAIL clr got empty_n=%b full_n=%b dout=%h exp 0 1 01", d2_empty_n, d2_full_n, d2_dout);
    else pass_cnt++;
    d2_enq = 1'b1; d2_din = 8'h03;
    step();
    d2_enq = 1'b0;
    total_cnt++;
    if (d2_dout !== 8'h03 || d2_empty_n !== 1'b1 || d2_full_n !== 1'b1)
      $display("FAIL clr_reenq got dout=%h empty_n=%b full_n=%b exp 03 1 1", d2_dout, d2_empty_n, d2_full_n);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    RST = 1'b1; d2_enq = 1'b1; d2_din = 8'h55;
    step();
    RST = 1'b0; d2_enq = 1'b0;
    total_cnt++;
    if (d2_empty_n !== 1'b0 || d2_full_n !== 1'b1 || d2_dout !== 8'h00)
      $display("FAIL midop_reset got empty_n=%b full_n=%b dout=%h exp 0 1 00", d2_empty_n, d2_full_n, d2_dout);
    else pass_cnt++;
    total_cnt++;
    if (d1_empty_n !== 1'b0 || d1_dout !== 8'h00)
      $display("FAIL midop_reset_d1 got empty_n=%b dout=%h exp 0 00", d1_empty_n, d1_dout);
    else pass_cnt++;
  endtask

  initial begin
    #1;
    test_reset();
    test_fill_drain();
    test_simul_enq_deq();
    test_back_to_back();
    test_depth1();
    test_clear();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
